// File: rtl/ascon_ctrl_fsm.sv
// Ascon-128 control sequencer: INIT(pa) -> AD(pb) -> PT(pb) -> FINAL(pa) -> tag.
// Optional abort path enabled by defining ASCON_CTRL_ABORT_EN.
module ascon_ctrl_fsm #(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6,
    parameter int CNT_W    = 3
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] nb_ad_i,
    input  logic [CNT_W-1:0] nb_pt_i,
    input  logic             data_valid_i,
`ifdef ASCON_CTRL_ABORT_EN
    input  logic             abort_i,
    output logic             error_o,
`endif
    output logic             data_ready_o,
    output logic [3:0]       round_o,
    output logic             init_state_o,
    output logic             en_state_o,
    output logic [1:0]       xor_up_sel_o,
    output logic [1:0]       xor_down_sel_o,
    output logic             cipher_valid_o,
    output logic             tag_valid_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [3:0] RND_LAST = 4'(ROUNDS_A - 1);
    localparam logic [3:0] RND_PB0  = 4'(ROUNDS_A - ROUNDS_B);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_AD_WAIT, S_AD_PERM, S_PT_WAIT, S_PT_PERM, S_FINAL, S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       rnd_q, rnd_d;
    logic [CNT_W-1:0] ad_cnt_q, ad_cnt_d;
    logic [CNT_W-1:0] pt_cnt_q, pt_cnt_d;
    logic             abort;
    logic             wait_st;
    logic             hs;
    logic             rnd_last;
    logic             pt_last;

`ifdef ASCON_CTRL_ABORT_EN
    logic error_q;

    assign abort   = abort_i && (state_q != S_IDLE);
    assign error_o = error_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) error_q <= 1'b0;
        else         error_q <= abort;
    end
`else
    assign abort = 1'b0;
`endif

    assign wait_st  = (state_q == S_AD_WAIT) || (state_q == S_PT_WAIT);
    // Abort takes priority: a handshake in the abort cycle is not consumed.
    assign hs       = wait_st && data_valid_i && !abort;
    assign rnd_last = (rnd_q == RND_LAST);
    assign pt_last  = (pt_cnt_q == CNT_W'(1));

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            rnd_q    <= '0;
            ad_cnt_q <= '0;
            pt_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            rnd_q    <= rnd_d;
            ad_cnt_q <= ad_cnt_d;
            pt_cnt_q <= pt_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rnd_d    = rnd_q;
        ad_cnt_d = ad_cnt_q;
        pt_cnt_d = pt_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_INIT;
                    rnd_d    = '0;
                    ad_cnt_d = (nb_ad_i == '0) ? CNT_W'(1) : nb_ad_i;
                    pt_cnt_d = (nb_pt_i == '0) ? CNT_W'(1) : nb_pt_i;
                end
            end
            S_INIT: begin
                if (rnd_last) begin
                    state_d = S_AD_WAIT;
                    rnd_d   = RND_PB0;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            S_AD_WAIT: begin
                if (hs) begin
                    state_d  = S_AD_PERM;
                    rnd_d    = RND_PB0 + 4'd1;
                    ad_cnt_d = ad_cnt_q - CNT_W'(1);
                end
            end
            S_AD_PERM: begin
                if (rnd_last) begin
                    // Counter already decremented at handshake: zero means last AD block.
                    state_d = (ad_cnt_q == '0) ? S_PT_WAIT : S_AD_WAIT;
                    rnd_d   = RND_PB0;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            S_PT_WAIT: begin
                if (hs) begin
                    pt_cnt_d = pt_cnt_q - CNT_W'(1);
                    if (pt_last) begin
                        state_d = S_FINAL;
                        rnd_d   = 4'd1;
                    end else begin
                        state_d = S_PT_PERM;
                        rnd_d   = RND_PB0 + 4'd1;
                    end
                end
            end
            S_PT_PERM: begin
                if (rnd_last) begin
                    state_d = S_PT_WAIT;
                    rnd_d   = RND_PB0;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            S_FINAL: begin
                if (rnd_last) begin
                    state_d = S_DONE;
                    rnd_d   = '0;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                rnd_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d  = S_IDLE;
            rnd_d    = '0;
            ad_cnt_d = '0;
            pt_cnt_d = '0;
        end
    end

    always_comb begin
        data_ready_o   = 1'b0;
        round_o        = 4'd0;
        init_state_o   = 1'b0;
        en_state_o     = 1'b0;
        xor_up_sel_o   = 2'd0;
        xor_down_sel_o = 2'd0;
        cipher_valid_o = 1'b0;
        tag_valid_o    = 1'b0;
        busy_o         = 1'b1;
        done_o         = 1'b0;
        unique case (state_q)
            S_IDLE: busy_o = 1'b0;
            S_INIT: begin
                en_state_o   = 1'b1;
                round_o      = rnd_q;
                init_state_o = (rnd_q == 4'd0);
                if (rnd_last) xor_down_sel_o = 2'd2;
            end
            S_AD_WAIT: begin
                data_ready_o = 1'b1;
                round_o      = rnd_q;
                if (hs) begin
                    en_state_o   = 1'b1;
                    xor_up_sel_o = 2'd1;
                end
            end
            S_AD_PERM: begin
                en_state_o = 1'b1;
                round_o    = rnd_q;
                if (rnd_last && ad_cnt_q == '0) xor_down_sel_o = 2'd1;
            end
            S_PT_WAIT: begin
                data_ready_o = 1'b1;
                // Last PT block jumps straight into round 0 of the final pa.
                round_o      = pt_last ? 4'd0 : rnd_q;
                if (hs) begin
                    en_state_o     = 1'b1;
                    cipher_valid_o = 1'b1;
                    xor_up_sel_o   = pt_last ? 2'd3 : 2'd1;
                end
            end
            S_PT_PERM: begin
                en_state_o = 1'b1;
                round_o    = rnd_q;
            end
            S_FINAL: begin
                en_state_o = 1'b1;
                round_o    = rnd_q;
                if (rnd_last) xor_down_sel_o = 2'd2;
            end
            S_DONE: begin
                tag_valid_o = 1'b1;
                done_o      = 1'b1;
            end
            default: busy_o = 1'b0;
        endcase
        if (abort) begin
            data_ready_o   = 1'b0;
            en_state_o     = 1'b0;
            xor_up_sel_o   = 2'd0;
            xor_down_sel_o = 2'd0;
            cipher_valid_o = 1'b0;
            tag_valid_o    = 1'b0;
            done_o         = 1'b0;
        end
    end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Directed bench for ascon_ctrl_fsm; expected per-cycle output words hand-derived
// from the sequencing rules. Abort scenario built only with ASCON_CTRL_ABORT_EN.
module tb_ascon_ctrl_fsm;

    logic       clk;
    logic       reset_i;
    logic       start_i;
    logic [2:0] nb_ad_i;
    logic [2:0] nb_pt_i;
    logic       data_valid_i;
    logic       data_ready_o;
    logic [3:0] round_o;
    logic       init_state_o;
    logic       en_state_o;
    logic [1:0] xor_up_sel_o;
    logic [1:0] xor_down_sel_o;
    logic       cipher_valid_o;
    logic       tag_valid_o;
    logic       busy_o;
    logic       done_o;
`ifdef ASCON_CTRL_ABORT_EN
    logic       abort_i;
    logic       error_o;
`endif

    int n_chk = 0;
    int n_bad = 0;
    int cv_cnt = 0;
    int tv_cnt = 0;
    int dn_cnt = 0;

    ascon_ctrl_fsm dut (
        .clock_i        (clk),
        .reset_i        (reset_i),
        .start_i        (start_i),
        .nb_ad_i        (nb_ad_i),
        .nb_pt_i        (nb_pt_i),
        .data_valid_i   (data_valid_i),
`ifdef ASCON_CTRL_ABORT_EN
        .abort_i        (abort_i),
        .error_o        (error_o),
`endif
        .data_ready_o   (data_ready_o),
        .round_o        (round_o),
        .init_state_o   (init_state_o),
        .en_state_o     (en_state_o),
        .xor_up_sel_o   (xor_up_sel_o),
        .xor_down_sel_o (xor_down_sel_o),
        .cipher_valid_o (cipher_valid_o),
        .tag_valid_o    (tag_valid_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ready, round, init, en, xor_up, xor_down, cipher_valid, tag_valid, busy, done}
    logic [14:0] outw;
    assign outw = {data_ready_o, round_o, init_state_o, en_state_o, xor_up_sel_o,
                   xor_down_sel_o, cipher_valid_o, tag_valid_o, busy_o, done_o};

    always @(negedge clk) begin
        if (cipher_valid_o) cv_cnt <= cv_cnt + 1;
        if (tag_valid_o)    tv_cnt <= tv_cnt + 1;
        if (done_o)         dn_cnt <= dn_cnt + 1;
    end

    function automatic logic [14:0] ew(int rdy, int rnd, int ini, int en, int xu, int xd,
                                       int cv, int tv, int bsy, int dn);
        return {rdy[0], 4'(rnd), ini[0], en[0], 2'(xu), 2'(xd), cv[0], tv[0], bsy[0], dn[0]};
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(string tag, logic [14:0] exp);
        #1 chk(tag, 32'(outw), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic adv();
        #1;
        @(posedge clk);
        #1;
    endtask

    // Full operation; noise=1 drives valid outside WAIT and pulses start during AD_PERM.
    task automatic op(int nad, int npt, int stall, bit noise);
        int ead;
        int ept;
        int rw;
        bit last;
        ead = (nad == 0) ? 1 : nad;
        ept = (npt == 0) ? 1 : npt;
        start_i = 1'b1; nb_ad_i = 3'(nad); nb_pt_i = 3'(npt); data_valid_i = noise;
        step("idle_start", ew(0,0,0,0,0,0,0,0,0,0));
        start_i = 1'b0;
        for (int r = 0; r < 12; r++) begin
            data_valid_i = noise;
            step("init", ew(0, r, (r == 0), 1, 0, (r == 11) ? 2 : 0, 0, 0, 1, 0));
        end
        for (int b = 0; b < ead; b++) begin
            for (int s = 0; s < stall; s++) begin
                data_valid_i = 1'b0;
                step("ad_wait", ew(1,6,0,0,0,0,0,0,1,0));
            end
            data_valid_i = 1'b1;
            step("ad_hs", ew(1,6,0,1,1,0,0,0,1,0));
            for (int r = 7; r < 12; r++) begin
                data_valid_i = noise; start_i = noise;
                step("ad_perm", ew(0, r, 0, 1, 0, (r == 11 && b == ead-1) ? 1 : 0, 0, 0, 1, 0));
                start_i = 1'b0;
            end
        end
        for (int b = 0; b < ept; b++) begin
            last = (b == ept-1);
            rw = last ? 0 : 6;
            for (int s = 0; s < stall; s++) begin
                data_valid_i = 1'b0;
                step("pt_wait", ew(1,rw,0,0,0,0,0,0,1,0));
            end
            data_valid_i = 1'b1;
            step("pt_hs", ew(1, rw, 0, 1, last ? 3 : 1, 0, 1, 0, 1, 0));
            if (!last) begin
                for (int r = 7; r < 12; r++) begin
                    data_valid_i = noise;
                    step("pt_perm", ew(0,r,0,1,0,0,0,0,1,0));
                end
            end
        end
        for (int r = 1; r < 12; r++) begin
            data_valid_i = noise;
            step("final", ew(0, r, 0, 1, 0, (r == 11) ? 2 : 0, 0, 0, 1, 0));
        end
        data_valid_i = 1'b0;
        step("done", ew(0,0,0,0,0,0,0,1,1,1));
        step("idle_after", ew(0,0,0,0,0,0,0,0,0,0));
    endtask

    initial begin
        int cv0;
        int tv0;
        int dn0;
        reset_i = 1'b1; start_i = 1'b0; nb_ad_i = '0; nb_pt_i = '0; data_valid_i = 1'b0;
`ifdef ASCON_CTRL_ABORT_EN
        abort_i = 1'b0;
`endif
        @(posedge clk); #1;
        step("reset_hold", ew(0,0,0,0,0,0,0,0,0,0));
        reset_i = 1'b0;
        data_valid_i = 1'b1;
        step("idle_no_start", ew(0,0,0,0,0,0,0,0,0,0));
        data_valid_i = 1'b0;

        // Reset in the middle of INIT
        start_i = 1'b1; nb_ad_i = 3'd1; nb_pt_i = 3'd1;
        step("rst_start", ew(0,0,0,0,0,0,0,0,0,0));
        start_i = 1'b0;
        for (int r = 0; r < 5; r++) step("rst_init", ew(0, r, (r == 0), 1, 0, 0, 0, 0, 1, 0));
        reset_i = 1'b1;
        step("rst_init5", ew(0,5,0,1,0,0,0,0,1,0));
        reset_i = 1'b0;
        step("rst_idle", ew(0,0,0,0,0,0,0,0,0,0));
        chk("rst_no_done", 32'(dn_cnt), 32'd0);

        // 1/1 with valid always high (plus ignored start/valid noise)
        cv0 = cv_cnt; tv0 = tv_cnt;
        op(1, 1, 0, 1'b1);
        chk("c11_cv", 32'(cv_cnt - cv0), 32'd1);
        chk("c11_tv", 32'(tv_cnt - tv0), 32'd1);

        // 2 AD / 3 PT with 4-cycle upstream stalls per block
        cv0 = cv_cnt; tv0 = tv_cnt;
        op(2, 3, 4, 1'b0);
        chk("c23_cv", 32'(cv_cnt - cv0), 32'd3);
        chk("c23_tv", 32'(tv_cnt - tv0), 32'd1);

        // Zero counts clamp to one block each
        cv0 = cv_cnt; tv0 = tv_cnt;
        op(0, 0, 0, 1'b1);
        chk("c00_cv", 32'(cv_cnt - cv0), 32'd1);
        chk("c00_tv", 32'(tv_cnt - tv0), 32'd1);

`ifdef ASCON_CTRL_ABORT_EN
        // Abort during FINAL round 4 (cycle 23 after the start cycle)
        dn0 = dn_cnt; tv0 = tv_cnt;
        abort_i = 1'b1;
        step("abort_idle_ign", ew(0,0,0,0,0,0,0,0,0,0));
        chk("abort_idle_err", 32'(error_o), 32'd0);
        abort_i = 1'b0;
        start_i = 1'b1; nb_ad_i = 3'd1; nb_pt_i = 3'd1; data_valid_i = 1'b1;
        adv();
        start_i = 1'b0;
        for (int c = 1; c < 23; c++) adv();
        #1 chk("abort_pre_rnd", 32'(round_o), 32'd4);
        abort_i = 1'b1;
        adv();
        abort_i = 1'b0; data_valid_i = 1'b0;
        #1 chk("abort_err", 32'(error_o), 32'd1);
        step("abort_idle", ew(0,0,0,0,0,0,0,0,0,0));
        chk("abort_err_clr", 32'(error_o), 32'd0);
        chk("abort_no_done", 32'(dn_cnt - dn0), 32'd0);
        chk("abort_no_tag", 32'(tv_cnt - tv0), 32'd0);
        op(1, 1, 0, 1'b0);
`else
        dn0 = dn_cnt;
        chk("done_total", 32'(dn0), 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
